// File: rtl/binary_matrix_scan.sv
// ============================================================================
// binary_matrix_scan
//   Multiplexes the four binary-clock digits onto a 4x4 LED matrix: one column
//   per digit, one row per bit. Each column is preceded by an all-off blanking
//   window and driven with 16-step PWM. Digits and brightness are captured once
//   per frame into shadow registers, so a counter carry in the middle of a scan
//   cannot tear the displayed time.
//
//   Parameters
//     COL_CYCLES    drive cycles per column (multiple of 16, >= 16)
//     BLANK_CYCLES  all-off cycles before each column (>= 1)
//   Ports
//     hwclk        in   system clock
//     rst          in   asynchronous active-high reset
//     dm0/dm1      in   minutes units/tens digit  -> columns 0/1
//     dh0/dh1      in   hours units/tens digit    -> columns 2/3
//     bright       in   PWM duty in sixteenths (0 = dark)
//     col          out  one-hot column enable, active-high
//     row          out  row drive, active-high (bit i of the active digit)
//     frame_start  out  one-cycle pulse at each frame boundary
//   Revision: 1.0
// ============================================================================
`default_nettype none

module binary_matrix_scan #(
  parameter int COL_CYCLES   = 3008,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic [3:0] dm0,
  input  logic [3:0] dm1,
  input  logic [3:0] dh0,
  input  logic [3:0] dh1,
  input  logic [3:0] bright,
  output logic [3:0] col,
  output logic [3:0] row,
  output logic       frame_start
);

  localparam int CNT_MAX = (COL_CYCLES > BLANK_CYCLES) ? COL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(COL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      ci, ci_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [3:0]      pwm, pwm_nx;
  logic [3:0][3:0] shadow;
  logic [3:0]      shadow_bright;
  logic            capture;
  logic [3:0]      col_nx, row_nx;

  // In BLANK, cnt runs 1..BLANK_CYCLES; every transition into BLANK loads 1.
  // cnt = 0 in BLANK therefore only occurs straight out of reset, which marks
  // the first edge after reset as a frame boundary of the same length as any
  // other blanking window.
  always_comb begin
    state_nx = state;
    ci_nx    = ci;
    cnt_nx   = cnt;
    pwm_nx   = pwm;
    capture  = 1'b0;
    col_nx   = 4'b0000;
    row_nx   = 4'b0000;

    unique case (state)
      BLANK: begin
        if (cnt == '0) begin
          capture = 1'b1;
          cnt_nx  = CNT_ONE;
        end else if (cnt == BLANK_LAST) begin
          state_nx = DRIVE;
          cnt_nx   = '0;
          pwm_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      DRIVE: begin
        pwm_nx = pwm + 4'd1;
        if (cnt == COL_LAST) begin
          state_nx = BLANK;
          cnt_nx   = CNT_ONE;
          ci_nx    = ci + 2'd1;
          capture  = (ci == 2'd3);
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: state_nx = BLANK;
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    if (state_nx == DRIVE) begin
      col_nx = 4'b0001 << ci_nx;
      if (pwm_nx < shadow_bright) begin
        row_nx = shadow[ci_nx];
      end
    end
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state         <= BLANK;
      ci            <= 2'd0;
      cnt           <= '0;
      pwm           <= 4'd0;
      shadow        <= '0;
      shadow_bright <= 4'd0;
      col           <= 4'b0000;
      row           <= 4'b0000;
      frame_start   <= 1'b0;
    end else begin
      state       <= state_nx;
      ci          <= ci_nx;
      cnt         <= cnt_nx;
      pwm         <= pwm_nx;
      col         <= col_nx;
      row         <= row_nx;
      frame_start <= capture;
      if (capture) begin
        shadow        <= {dh1, dh0, dm1, dm0};
        shadow_bright <= bright;
      end
    end
  end

endmodule

`default_nettype wire
